// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, widths and defaults for the instruction cache
package icache_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int DEF_LINES = 8;
  localparam int DEF_WORDS = 4;
  localparam logic [DATA_W-1:0] DEF_NOP_INSTR = 16'h0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines, input int words);
    return ADDR_W - $clog2(lines) - $clog2(words);
  endfunction

  localparam int DEF_OFF_W = off_width(DEF_WORDS);
  localparam int DEF_IDX_W = idx_width(DEF_LINES);
  localparam int DEF_TAG_W = tag_width(DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage, async read, sync write, clear-all
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int IDX_W = DEF_IDX_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_all
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES][WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_off];

  // Valid bits: a line is invalid while it is being refilled and valid only after its last word lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_last;
    end
  end

  // Tag and data arrays are not reset; the valid bit guards them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]          <= wr_tag;
      data_mem[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped icache with refill FSM; ICACHE_STATS_EN adds hit/miss counters
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int                LINES     = DEF_LINES,
  parameter int                WORDS     = DEF_WORDS,
  parameter logic [DATA_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic        fetch_en,
  input  logic        inv,
  output logic [15:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [15:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OFF_W  = off_width(WORDS);
  localparam int IDX_W  = idx_width(LINES);
  localparam int TAG_W  = tag_width(LINES, WORDS);
  localparam int LINE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              wr_en;
  logic              wr_last;
  logic              clr_all;

  assign pc_off = pc_in[OFF_W-1:0];
  assign pc_idx = pc_in[OFF_W +: IDX_W];
  assign pc_tag = pc_in[ADDR_W-1 -: TAG_W];

  assign hit = fetch_en && rd_valid && (rd_tag == pc_tag) && (state_q == ST_IDLE);

  // The line being filled is held as {tag, index}; the word counter supplies the offset
  assign mem_addr = {line_q, cnt_q};

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pc_idx),
    .rd_off   (pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_last  (wr_last),
    .wr_idx   (line_q[IDX_W-1:0]),
    .wr_off   (cnt_q),
    .wr_tag   (line_q[LINE_W-1 -: TAG_W]),
    .wr_data  (mem_rdata),
    .clr_all  (clr_all)
  );

  // State, fill line and word counter registers; reset drops mem_req at once via state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  // Next state and outputs; inv wins over both a new miss and a word arriving in FILL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    clr_all = 1'b0;
    mem_req = (state_q == ST_FILL);
    stall   = (state_q == ST_FILL) || (fetch_en && !hit);
    instr   = hit ? rd_data : NOP_INSTR;
    case (state_q)
      ST_IDLE: begin
        if (inv) begin
          clr_all = 1'b1;
        end else if (fetch_en && !hit) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          line_d  = {pc_tag, pc_idx};
        end
      end
      ST_FILL: begin
        if (inv) begin
          clr_all = 1'b1;
          state_d = ST_IDLE;
        end else if (mem_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_OFF) begin
            wr_last = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Saturating hit/miss counters; a miss is counted once, on the IDLE to FILL step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if ((state_q == ST_IDLE) && (state_d == ST_FILL) && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - scoreboard bench for icache_ctrl (ICACHE_STATS_EN optional)
module tb_icache_ctrl;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_in = '0;
  logic        fetch_en = 1'b0;
  logic        inv = 1'b0;
  logic [15:0] instr;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mem_wait = 0;
  int wctr = 0;
  bit req_seen = 1'b0;
  int n;
  logic [15:0] addr_q[$];
  logic [15:0] instr_q[$];

  icache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .fetch_en  (fetch_en),
    .inv       (inv),
    .instr     (instr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model and address scoreboard: mem_valid comes mem_wait cycles after each word request
  always begin
    @(negedge clk);
    #1;
    if (mem_valid || !mem_req) wctr = 0;
    else if (req_seen) wctr++;
    req_seen  = mem_req;
    mem_valid = mem_req && (wctr >= mem_wait);
    mem_rdata = mem_addr + 16'h1000;
    if (mem_req) begin
      if (addr_q.size() == 0) begin
        check("mem_unexp", mem_addr, 16'hFFFF);
      end else begin
        check("mem_addr", mem_addr, addr_q[0]);
        if (mem_valid && !inv) void'(addr_q.pop_front());
      end
    end
  end

  task automatic push_line(input logic [15:0] pc);
    for (int i = 0; i < 4; i++) addr_q.push_back({pc[15:2], 2'b00} + 16'(i));
  endtask

  task automatic wait_result(input int exp_stall);
    int k = 0;
    logic [15:0] e;
    while (stall && k < 200) begin
      check("stall_instr_nop", instr, NOP);
      @(negedge clk);
      #2;
      k++;
    end
    check("fill_timeout", stall, 0);
    if (instr_q.size() == 0) begin
      check("instr_unexp", instr, 16'hFFFF);
    end else begin
      e = instr_q.pop_front();
      check("instr", instr, e);
    end
    if (exp_stall >= 0) check("stall_cycles", k, exp_stall);
  endtask

  task automatic fetch(input logic [15:0] pc, input int exp_stall);
    @(negedge clk);
    pc_in    = pc;
    fetch_en = 1'b1;
    inv      = 1'b0;
    if (exp_stall > 0) push_line(pc);
    instr_q.push_back(pc + 16'h1000);
    #2;
    wait_result(exp_stall);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      fetch_en = 1'b0;
      inv      = 1'b0;
    end
    #2;
  endtask

  task automatic wait_addr(input logic [15:0] a, input string tag);
    int k = 0;
    while (!(mem_req && mem_addr == a) && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    check(tag, mem_addr, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr", instr, NOP);
`ifdef ICACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // cold misses and hits: 3 misses, 9 hit cycles
    fetch(16'h0000, 5);
    fetch(16'h0001, 0);
    fetch(16'h0002, 0);
    fetch(16'h0003, 0);
    fetch(16'h0004, 5);
    fetch(16'h0005, 0);
    fetch(16'h0006, 0);
    fetch(16'h0007, 0);
    fetch(16'h0008, 5);
    idle(1);
`ifdef ICACHE_STATS_EN
    check("miss_cnt", miss_cnt, 3);
    check("hit_cnt", hit_cnt, 9);
`endif
    check("idle_stall", stall, 0);
    check("idle_instr", instr, NOP);

    // conflict miss on index 0
    fetch(16'h0020, 5);
    fetch(16'h0021, 0);
    fetch(16'h0000, 5);

    // two wait states per word
    mem_wait = 2;
    fetch(16'h0030, 13);
    mem_wait = 0;
    fetch(16'h0031, 0);

    // inv in IDLE: resident lines miss again
    idle(1);
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    fetch(16'h0000, 5);
    fetch(16'h0006, 5);

    // redirect during word 1 of a fill
    @(negedge clk);
    pc_in    = 16'h0040;
    fetch_en = 1'b1;
    push_line(16'h0040);
    push_line(16'h0008);
    instr_q.push_back(16'h1008);
    #2;
    wait_addr(16'h0041, "redirect_word1");
    pc_in = 16'h0008;
    wait_result(-1);
    check("redirect_q_drained", addr_q.size(), 0);
    fetch(16'h0042, 0);

    // inv during word 2 aborts the fill; refetch restarts at offset 0
    @(negedge clk);
    pc_in    = 16'h0050;
    fetch_en = 1'b1;
    push_line(16'h0050);
    instr_q.push_back(16'h1050);
    #2;
    wait_addr(16'h0052, "inv_word2");
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    #2;
    check("inv_req_drop", mem_req, 0);
    check("inv_refetch_stall", stall, 1);
    addr_q.delete();
    push_line(16'h0050);
    wait_result(5);
    fetch(16'h0042, 5);

`ifdef ICACHE_STATS_EN
    // hit counter saturation
    idle(1);
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    fetch(16'h0051, 0);
    idle(1);
    check("hit_cnt_sat", hit_cnt, 16'hFFFF);
`endif

    // reset during a fill drops mem_req immediately
    @(negedge clk);
    pc_in    = 16'h0060;
    fetch_en = 1'b1;
    push_line(16'h0060);
    #2;
    wait_addr(16'h0061, "rst_fill_word1");
    rst_n = 1'b0;
    #1;
    check("rst_req_async", mem_req, 0);
    check("rst_addr_async", mem_addr, 0);
    addr_q.delete();
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(16'h0050, 5);

    idle(2);
    check("final_addr_q_empty", addr_q.size(), 0);
    check("final_instr_q_empty", instr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
